// File: rtl/bcd_frame_converter_if.sv
// Digit-stream and result-port bundle for bcd_frame_converter.
// The master side feeds BCD digits and consumes results; the slave side is the converter.
interface bcd_frame_converter_if #(
    parameter int BIN_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       bcd_digit;
    logic             dec_valid;
    logic [3:0]       dec;
    logic             dig_err;
    logic             res_valid;
    logic             res_ready;
    logic [BIN_W-1:0] res_bin;
    logic             res_err;

    modport master (
        output in_valid, bcd_digit, res_ready,
        input  in_ready, dec_valid, dec, dig_err, res_valid, res_bin, res_err
    );

    modport slave (
        input  in_valid, bcd_digit, res_ready,
        output in_ready, dec_valid, dec, dig_err, res_valid, res_bin, res_err
    );
endinterface

// File: rtl/bcd_frame_converter.sv
// BCD frame converter: sanitises an MSD-first BCD digit stream, echoes each
// digit, and folds every NDIG digits into a binary result behind a handshake.
// Halts after MAX_FRAMES delivered results (0 = never).
module bcd_frame_converter #(
    parameter int NDIG       = 3,
    parameter int BIN_W      = 10,
    parameter int MAX_FRAMES = 300,
    parameter int ERR_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_frame_converter_if.slave bus,
    output logic [ERR_W-1:0]     err_count,
    output logic [15:0]          frame_count,
    output logic                 done
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BIN_W-1:0]   acc_q;
    logic               frame_err_q;
    logic               in_ready_q;
    logic [3:0]         dec_q;
    logic               dec_valid_q;
    logic               dig_err_q;
    logic               res_valid_q;
    logic [BIN_W-1:0]   res_bin_q;
    logic               res_err_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic [15:0]        frame_cnt_q;
    logic               done_q;

    logic               accept_s;
    logic               digit_bad_s;
    logic [3:0]         digit_s;
    logic               last_s;
    logic               handshake_s;
    logic               hit_max_s;
    logic [BIN_W-1:0]   acc_d;
    logic [ERR_W-1:0]   err_cnt_d;
    logic [15:0]        frame_cnt_d;

    // Per-cycle decode: accept/handshake qualifiers, sanitised digit and next-value arithmetic.
    always_comb begin
        accept_s    = bus.in_valid & in_ready_q;
        handshake_s = res_valid_q & bus.res_ready;
        digit_bad_s = (bus.bcd_digit > 4'd9);
        digit_s     = digit_bad_s ? 4'd0 : bus.bcd_digit;
        last_s      = (idx_q == IDX_W'(NDIG - 1));
        acc_d       = (acc_q * BIN_W'(32'd10)) + BIN_W'(digit_s);
        err_cnt_d   = (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q : (err_cnt_q + ERR_W'(1'b1));
        frame_cnt_d = frame_cnt_q + 16'd1;
        hit_max_s   = (MAX_FRAMES != 0) && ({16'd0, frame_cnt_d} == 32'(MAX_FRAMES));
    end

    // Frame FSM with all outputs registered; in_ready is high exactly while in ACCUM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            idx_q       <= '0;
            acc_q       <= '0;
            frame_err_q <= 1'b0;
            in_ready_q  <= 1'b1;
            dec_q       <= 4'd0;
            dec_valid_q <= 1'b0;
            dig_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_bin_q   <= '0;
            res_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            frame_cnt_q <= 16'd0;
            done_q      <= 1'b0;
        end else begin
            dec_valid_q <= 1'b0;
            dig_err_q   <= 1'b0;
            case (state_q)
                ST_ACCUM: begin
                    if (accept_s) begin
                        dec_q       <= digit_s;
                        dec_valid_q <= 1'b1;
                        dig_err_q   <= digit_bad_s;
                        if (digit_bad_s) begin
                            err_cnt_q <= err_cnt_d;
                        end
                        if (last_s) begin
                            // Frame complete: publish result and clear the accumulator for the next one.
                            res_bin_q   <= acc_d;
                            res_err_q   <= frame_err_q | digit_bad_s;
                            res_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= ST_HOLD;
                            acc_q       <= '0;
                            idx_q       <= '0;
                            frame_err_q <= 1'b0;
                        end else begin
                            acc_q       <= acc_d;
                            idx_q       <= idx_q + IDX_W'(1'b1);
                            frame_err_q <= frame_err_q | digit_bad_s;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result held stable until the consumer takes it; no digit accepted meanwhile.
                    if (handshake_s) begin
                        res_valid_q <= 1'b0;
                        frame_cnt_q <= frame_cnt_d;
                        if (hit_max_s) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_ACCUM;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    in_ready_q <= 1'b0;
                    done_q     <= 1'b1;
                end
                default: begin
                    state_q    <= ST_ACCUM;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.dec       = dec_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.dig_err   = dig_err_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_bin   = res_bin_q;
    assign bus.res_err   = res_err_q;
    assign err_count     = err_cnt_q;
    assign frame_count   = frame_cnt_q;
    assign done          = done_q;

endmodule
